// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: byte stream -> little-endian 32-bit word writes,
// trailing XOR checksum, core held in reset until a good image is in place.
module imem_loader #(
  parameter int MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] HDR0  = 3'd0;
  localparam logic [2:0] HDR1  = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] CHK   = 3'd4;
  localparam logic [2:0] DONE  = 3'd5;
  localparam logic [2:0] ERR   = 3'd6;

  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  logic [2:0]  state;
  logic [15:0] n_words;
  logic [15:0] word_idx;
  logic [1:0]  byte_idx;
  logic [7:0]  csum;
  logic [23:0] shreg;
  logic [15:0] n_hdr;

  assign n_hdr = {in_byte, n_words[7:0]};

  // All outputs decode from the state register; in_ready never looks at in_valid.
  assign in_ready   = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CHK);
  assign wr_en      = (state == WRITE);
  assign done       = (state == DONE);
  assign error      = (state == ERR);
  assign core_reset = (state != DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HDR0;
      n_words  <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      csum     <= '0;
      shreg    <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      case (state)
        HDR0: if (in_valid) begin
          n_words[7:0] <= in_byte;
          state        <= HDR1;
        end
        HDR1: if (in_valid) begin
          n_words[15:8] <= in_byte;
          if ({1'b0, n_hdr} > MAXW) state <= ERR;
          else if (n_hdr == 16'd0)  state <= CHK;
          else                      state <= DATA;
        end
        DATA: if (in_valid) begin
          csum     <= csum ^ in_byte;
          byte_idx <= byte_idx + 2'd1;
          shreg    <= {in_byte, shreg[23:8]};
          // Address/data are latched here so they stay put after the strobe.
          if (byte_idx == 2'd3) begin
            wr_data <= {in_byte, shreg};
            wr_addr <= {14'd0, word_idx, 2'b00};
            state   <= WRITE;
          end
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
          byte_idx <= '0;
          state    <= (word_idx + 16'd1 == n_words) ? CHK : DATA;
        end
        CHK: if (in_valid) begin
          state <= (in_byte == csum) ? DONE : ERR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader against a stream-level reference model.
module tb_imem_loader;
  localparam int MW = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready, wr_en, core_reset, done, error;
  logic [31:0] wr_addr, wr_data;

  imem_loader #(.MAX_WORDS(MW)) dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .core_reset(core_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  stream[$];
  logic [63:0] exp_w[$];
  logic [63:0] got[$];
  logic [63:0] ref_w[$];
  int          nw;
  bit          exp_over, exp_good;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Collect every write; in_ready must be low exactly in WRITE/DONE/ERR cycles.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) got.push_back({wr_addr, wr_data});
      chk("rdy", 64'(in_ready), 64'(!(wr_en || done || error)));
    end
  end

  // Reference: parse the whole stream with plain arithmetic.
  function automatic void model();
    logic [7:0]  cs;
    logic [31:0] w;
    int          p;
    nw = {stream[1], stream[0]};
    exp_over = (nw > MW);
    exp_w.delete();
    exp_good = 1'b0;
    if (!exp_over) begin
      cs = 8'h00;
      for (int k = 0; k < nw; k++) begin
        p = 2 + 4 * k;
        w = {stream[p+3], stream[p+2], stream[p+1], stream[p]};
        cs = cs ^ stream[p] ^ stream[p+1] ^ stream[p+2] ^ stream[p+3];
        exp_w.push_back({32'(4 * k), w});
      end
      exp_good = (stream[2 + 4 * nw] == cs);
    end
  endfunction

  task automatic make_image(input int n, input bit corrupt);
    logic [7:0] cs, b;
    stream.delete();
    stream.push_back(8'(n));
    stream.push_back(8'(n >> 8));
    if (n <= MW) begin
      cs = 8'h00;
      for (int k = 0; k < 4 * n; k++) begin
        b = 8'($urandom);
        cs ^= b;
        stream.push_back(b);
      end
      stream.push_back(corrupt ? (cs ^ 8'(1 << $urandom_range(0, 7))) : cs);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_addr", 64'(wr_addr), 64'd0);
    chk("rst_data", 64'(wr_data), 64'd0);
    chk("rst_core_reset", 64'(core_reset), 64'd1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    reset = 1'b0;
    got.delete();
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic drive(input logic [7:0] b, input int gap);
    bit acc;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    acc = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      acc = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic run(input string tag, input int gap_max);
    int kk;
    model();
    for (int i = 0; i < stream.size(); i++) begin
      if (done || error) break;
      drive(stream[i], (gap_max > 0) ? $urandom_range(0, gap_max) : 0);
      if (i == 1 && exp_over) chk({tag, "_over_err"}, 64'(error), 64'd1);
      if (!exp_over && i >= 2 && i < 2 + 4 * nw && ((i - 2) % 4) == 3) begin
        kk = (i - 2) / 4;
        chk({tag, "_wr_en"}, 64'(wr_en), 64'd1);
        chk({tag, "_wr"}, {wr_addr, wr_data}, exp_w[kk]);
      end
      if (!exp_over && i == 2 + 4 * nw) begin
        chk({tag, "_done"}, 64'(done), 64'(exp_good));
        chk({tag, "_core_reset"}, 64'(core_reset), 64'(!exp_good));
      end
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk({tag, "_nwrites"}, 64'(got.size()), 64'(exp_w.size()));
    for (int k = 0; k < exp_w.size(); k++) chk({tag, "_word"}, got[k], exp_w[k]);
    chk({tag, "_error"}, 64'(error), 64'(exp_over || !exp_good));
    chk({tag, "_final_done"}, 64'(done), 64'(!exp_over && exp_good));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
    repeat (2) @(negedge clk);
    do_reset();

    stream = '{8'h02, 8'h00, 8'h33, 8'h06, 8'h23, 8'h00, 8'hB3, 8'h09, 8'h5A, 8'h01, 8'hF7};
    run("two_word", 0);
    chk("two_word_w0", got[0], 64'h00000000_00230633);
    chk("two_word_w1", got[1], 64'h00000004_015A09B3);

    do_reset();
    stream[stream.size() - 1] ^= 8'hFF;
    run("bad_cs", 0);
    chk("bad_cs_ready", 64'(in_ready), 64'd0);
    chk("bad_cs_core_reset", 64'(core_reset), 64'd1);

    do_reset();
    stream = '{8'(MW + 1), 8'h00};
    run("oversize", 0);

    do_reset();
    make_image(MW, 1'b0);
    run("max", 1);
    chk("max_last_addr", 64'(got[MW - 1][63:32]), 64'((MW - 1) * 4));

    do_reset();
    stream = '{8'h00, 8'h00, 8'h00};
    run("empty", 0);
    do_reset();
    stream = '{8'h00, 8'h00, 8'h01};
    run("empty_bad", 0);

    do_reset();
    make_image(5, 1'b0);
    run("nogap", 0);
    ref_w = got;
    do_reset();
    run("gaps", 3);
    chk("gaps_count", 64'(got.size()), 64'(ref_w.size()));
    for (int k = 0; k < ref_w.size(); k++) chk("gaps_same", got[k], ref_w[k]);

    for (int t = 0; t < 6; t++) begin
      do_reset();
      make_image($urandom_range(0, MW + 1), ($urandom_range(0, 3) == 0));
      run("rand", 2);
    end

    do_reset();
    stream = '{8'h02, 8'h00, 8'hAA, 8'h55};
    for (int i = 0; i < stream.size(); i++) drive(stream[i], 0);
    do_reset();
    make_image(1, 1'b0);
    run("after_rst", 1);
    chk("after_rst_addr", 64'(got[0][63:32]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
